// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x WIDTH register file, NRD read / NWR write ports.
// Highest write port wins; optional bypass, zero reg, registered read.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  localparam int AW      = $clog2(DEPTH),
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  output logic                 wr_conflict
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_conflict;
  logic             w_conflict;
  logic [AW-1:0]    w_wa [NWR];
  logic [WIDTH-1:0] w_wd [NWR];
  logic             w_we [NWR];

  // unpack write ports; writes to r0 are masked out here
  for (genvar j = 0; j < NWR; j++) begin : g_wp
    assign w_wa[j] = wr_addr[j*AW +: AW];
    assign w_wd[j] = wr_data[j*WIDTH +: WIDTH];
    assign w_we[j] = wr_en[j] &&
                     !(ZERO_REG != 0 && w_wa[j] == '0);
  end

  // storage update; later ports overwrite earlier ones
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mem <= '{default: '0};
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_we[j]) r_mem[w_wa[j]] <= w_wd[j];
      end
    end
  end

  // detect two enabled writes to one live address
  always_comb begin
    w_conflict = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (w_we[j] && w_we[k] && w_wa[j] == w_wa[k])
          w_conflict = 1'b1;
      end
    end
  end

  // conflict flag lasts one cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_conflict <= 1'b0;
    else         r_conflict <= w_conflict;
  end

  assign wr_conflict = r_conflict;

  for (genvar i = 0; i < NRD; i++) begin : g_rp
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_rd;

    assign w_ra = rd_addr[i*AW +: AW];

    // stored value, overridden by bypass, then zero reg
    always_comb begin
      w_rd = r_mem[w_ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && w_wa[j] == w_ra) w_rd = w_wd[j];
        end
      end
      if (ZERO_REG != 0 && w_ra == '0) w_rd = '0;
    end

    if (RD_REG != 0) begin : g_reg
      logic [WIDTH-1:0] r_rd;

      // capture read value when enabled, else hold
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)       r_rd <= '0;
        else if (rd_en[i]) r_rd <= w_rd;
      end

      assign rd_data[i*WIDTH +: WIDTH] = r_rd;
    end else begin : g_comb
      logic w_unused_en;
      assign w_unused_en = rd_en[i];
      assign rd_data[i*WIDTH +: WIDTH] = w_rd;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks on three regfile_mp builds
// (bypass comb read, no-bypass comb read, registered read).
module tb_regfile_mp;

  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int NRD = 4;
  localparam int NWR = 2;

  logic               clk;
  logic               arst_n;
  logic [NRD-1:0]     rd_en;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*W-1:0]   wr_data;
  logic [NRD*W-1:0]   rd_a, rd_b, rd_c;
  logic               cf_a, cf_b, cf_c;

  int n_run;
  int n_fail;

  regfile_mp #(.BYPASS(1), .RD_REG(0)) u_a (
    .clk(clk), .arst_n(arst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_conflict(cf_a)
  );

  regfile_mp #(.BYPASS(0), .RD_REG(0)) u_b (
    .clk(clk), .arst_n(arst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_conflict(cf_b)
  );

  regfile_mp #(.BYPASS(1), .RD_REG(1)) u_c (
    .clk(clk), .arst_n(arst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_conflict(cf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    rd_en = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [W-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a[AW-1:0];
    wr_data[p*W +: W] = d;
  endtask

  task automatic ra(input int p, input int a);
    rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic ra_all(input int a);
    for (int p = 0; p < NRD; p++) ra(p, a);
  endtask

  function automatic logic [W-1:0] pa(input logic [NRD*W-1:0] v,
                                      input int p);
    return v[p*W +: W];
  endfunction

  initial begin
    n_run = 0;
    n_fail = 0;
    arst_n = 1'b0;
    rd_en = '0;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    step();
    step();
    arst_n = 1'b1;
    ra_all(5);
    #3;
    chk("rst_a_p0", pa(rd_a, 0), 32'h0);
    chk("rst_c_p1", pa(rd_c, 1), 32'h0);
    chk("rst_cf", {31'b0, cf_a}, 32'h0);

    // write r5 then async clear mid-cycle
    step();
    wr(0, 5, 32'hDEADBEEF);
    step();
    idle();
    #3;
    chk("wr_r5", pa(rd_a, 0), 32'hDEADBEEF);
    #1 arst_n = 1'b0;
    #1;
    for (int p = 0; p < NRD; p++)
      chk($sformatf("arst_r5_p%0d", p), pa(rd_a, p), 32'h0);
    #1 arst_n = 1'b1;

    // zero register via both ports
    step();
    wr(0, 0, 32'hFFFFFFFF);
    wr(1, 0, 32'hFFFFFFFF);
    ra_all(0);
    #3;
    chk("zero_byp_p3", pa(rd_a, 3), 32'h0);
    step();
    idle();
    #3;
    chk("zero_cf", {31'b0, cf_a}, 32'h0);
    for (int p = 0; p < NRD; p++)
      chk($sformatf("zero_p%0d", p), pa(rd_a, p), 32'h0);
    chk("zero_b_p1", pa(rd_b, 1), 32'h0);

    // write priority and conflict pulse
    step();
    wr(0, 7, 32'h11111111);
    wr(1, 7, 32'h22222222);
    ra_all(7);
    step();
    idle();
    #3;
    chk("prio_r7", pa(rd_b, 0), 32'h22222222);
    chk("prio_cf1", {31'b0, cf_a}, 32'h1);
    step();
    #3;
    chk("prio_cf0", {31'b0, cf_a}, 32'h0);

    // same-cycle bypass
    step();
    wr(0, 3, 32'hAAAA0000);
    step();
    idle();
    wr(0, 3, 32'h0000BBBB);
    ra(2, 3);
    #3;
    chk("byp_on", pa(rd_a, 2), 32'h0000BBBB);
    chk("byp_off", pa(rd_b, 2), 32'hAAAA0000);
    step();
    idle();
    wr(0, 4, 32'h44440000);
    wr(1, 4, 32'h00005555);
    ra(3, 4);
    #3;
    chk("byp_prio", pa(rd_a, 3), 32'h00005555);
    chk("byp_off_r4", pa(rd_b, 3), 32'h0);

    // registered read
    step();
    idle();
    wr(0, 9, 32'h12345678);
    step();
    idle();
    rd_en[1] = 1'b1;
    ra(1, 9);
    step();
    chk("rreg_cap", pa(rd_c, 1), 32'h12345678);
    idle();
    wr(0, 9, 32'h0);
    step();
    idle();
    chk("rreg_hold", pa(rd_c, 1), 32'h12345678);
    #3;
    chk("rreg_comb0", pa(rd_a, 1), 32'h0);
    step();
    rd_en[0] = 1'b1;
    ra(0, 9);
    wr(1, 9, 32'hCAFEF00D);
    step();
    idle();
    chk("rreg_byp", pa(rd_c, 0), 32'hCAFEF00D);

    // full sweep, two writes per cycle
    for (int c = 0; c < 16; c++) begin
      step();
      idle();
      wr(0, 2*c, (2*c) * 32'h01010101);
      wr(1, 2*c + 1, (2*c + 1) * 32'h01010101);
    end
    step();
    idle();
    for (int k = 0; k < 32; k++) begin
      for (int p = 0; p < NRD; p++) ra(p, (k + p) % 32);
      #3;
      for (int p = 0; p < NRD; p++) begin
        int a;
        a = (k + p) % 32;
        chk($sformatf("sweep_r%0d_p%0d", a, p), pa(rd_a, p),
            (a == 0) ? 32'h0 : a * 32'h01010101);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the superscalar datapath. Replaces the fixed 32x32, single-read-port mux tree.
- Holds DEPTH words of WIDTH bits. Provides NRD read ports and NWR write ports.
- Supports same-cycle write-to-read bypass, a hardwired zero register, and an optional registered read stage.
- Sits in the decode stage. The issue-width read/write pairs connect to the dual-issue pipeline.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- NRD, 4, number of read ports, 1..8.
- NWR, 2, number of write ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = a read returns data being written in the same cycle.
- RD_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.

Ports:
- clk  in  1  rising-edge clock
- arst_n  in  1  asynchronous active-low reset
- rd_en  in  NRD  per-port read enable (used only when RD_REG=1)
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  out  NRD*WIDTH  read data; port i at [i*WIDTH +: WIDTH]
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses; port j at [j*AW +: AW]
- wr_data  in  NWR*WIDTH  write data; port j at [j*WIDTH +: WIDTH]
- wr_conflict  out  1  registered flag: two or more enabled write ports targeted the same non-zero address last cycle

Behaviour:
- Reset
  - arst_n low clears every register, the rd_data registers (RD_REG=1) and wr_conflict to 0, immediately, without waiting for clk.
  - Deassertion is synchronised externally; the block only needs the async clear.
  - Reset asserted during a write cycle: the write is lost and the register stays 0.
- Write
  - On the rising clk edge, each port j with wr_en[j]=1 stores wr_data[j] to wr_addr[j].
  - Priority: when several enabled ports share an address, the highest index j wins.
  - wr_conflict is set to 1 for exactly the next cycle when that happens. It is not set for address 0 when ZERO_REG=1.
- Zero register (ZERO_REG=1)
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, regardless of bypass.
- Read with RD_REG=0
  - rd_data[i] is a combinational function of rd_addr[i], current storage and, if BYPASS=1, the current write ports. Zero-cycle latency.
  - rd_en is ignored.
- Bypass (BYPASS=1)
  - If any enabled write port matches rd_addr[i] this cycle, rd_data[i] returns that port's wr_data.
  - If several match, the highest index wins, the same rule as the write.
  - With BYPASS=0 the read returns the pre-edge stored value.
- Read with RD_REG=1
  - On the clk edge where rd_en[i]=1, rd_data[i] captures the value RD_REG=0 would show that cycle, including bypass.
  - It is visible the cycle after. When rd_en[i]=0, rd_data[i] holds its value.
- Address range: all AW-bit addresses are valid, so there is no out-of-range case.
- Read ports are independent. Any number may read the same address simultaneously.
- No X propagation: storage is initialised by reset only. Reads before the first reset are unspecified.

Test Plan:
- Reset and basic write
  - Stimulus: assert arst_n=0 mid-cycle after writing 0xDEADBEEF to r5, then release; read r5 on all ports.
  - Required: 0x00000000, with the clear occurring before the next clk edge.
- Zero register
  - Stimulus: write 0xFFFFFFFF to r0 via port 0 and port 1.
  - Required: all read ports return 0 on r0, and wr_conflict stays 0.
- Write priority
  - Stimulus: same cycle, port0 writes 0x11111111 and port1 writes 0x22222222 to r7.
  - Required: r7 reads 0x22222222 the next cycle; wr_conflict=1 for one cycle, then 0.
- Bypass (BYPASS=1, RD_REG=0)
  - Stimulus: r3 holds 0xAAAA0000; in one cycle write 0x0000BBBB to r3 while port2 reads r3.
  - Required: rd_data[2]=0x0000BBBB in that same cycle.
  - Repeat with BYPASS=0: rd_data[2]=0xAAAA0000.
- Registered read (RD_REG=1)
  - Stimulus: rd_en[1]=1, rd_addr[1]=r9 holding 0x12345678.
  - Required: rd_data[1]=0x12345678 one cycle later.
  - Then drop rd_en[1] and write r9=0x0; required: rd_data[1] holds 0x12345678.
- Full sweep (NRD=4, NWR=2)
  - Stimulus: write each address k with value k*0x01010101, two per cycle; then read all addresses on all ports in rotation.
  - Required: every read matches; r0 reads 0.
